// File: rtl/mode_annunciator.sv
// mode_annunciator: two-character mode indicator ("Hr", "An", "Pn", "AL") for the
// clock's 7-segment display. The indicator blinks during time-set and alternates
// with "AL" while the alarm rings. A prescaler derives the blink half-period from
// the system clock. All outputs are registered.
module mode_annunciator #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_24h,
    input  logic       flag_pm,
    input  logic       flag_set,
    input  logic       flag_alarm,
    output logic [6:0] seg_0,
    output logic [6:0] seg_1,
    output logic       blink_phase
);

    // Cycles per blink half-period
    localparam int DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("mode_annunciator: CLK_HZ/(2*BLINK_HZ) must be at least 2");
    end

    // Glyphs, lit-high, bit order gfedcba
    localparam logic [6:0] GLYPH_H     = 7'b1110110;
    localparam logic [6:0] GLYPH_R     = 7'b1010000;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_N     = 7'b1010100;
    localparam logic [6:0] GLYPH_P     = 7'b1110011;
    localparam logic [6:0] GLYPH_L     = 7'b0111000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Output polarity mask: XOR with all-ones inverts for active-low segments
    localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_SET,
        MODE_ALARM
    } mode_t;

    mode_t         r_mode;
    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic [6:0]    r_seg0;
    logic [6:0]    r_seg1;

    mode_t         w_mode;
    logic          w_restart;
    logic          w_wrap;
    logic [CW-1:0] w_cnt_next;
    logic          w_phase_next;
    logic [6:0]    w_base0;
    logic [6:0]    w_base1;
    logic [6:0]    w_lit0;
    logic [6:0]    w_lit1;

    // Effective mode, prescaler next state and lit-high glyph selection
    always_comb begin
        w_mode       = MODE_NORMAL;
        w_restart    = 1'b0;
        w_wrap       = 1'b0;
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        w_base0      = GLYPH_BLANK;
        w_base1      = GLYPH_BLANK;
        w_lit0       = GLYPH_BLANK;
        w_lit1       = GLYPH_BLANK;

        if (flag_alarm) begin
            w_mode = MODE_ALARM;
        end else if (flag_set) begin
            w_mode = MODE_SET;
        end

        // A mode change restarts the blink on phase 0 and takes precedence over the wrap
        w_restart = (w_mode != r_mode);
        w_wrap    = (r_cnt == CNT_LAST);
        if (w_restart) begin
            w_cnt_next   = '0;
            w_phase_next = 1'b0;
        end else if (w_wrap) begin
            w_cnt_next   = '0;
            w_phase_next = ~r_phase;
        end else begin
            w_cnt_next   = r_cnt + 1'b1;
        end

        if (flag_24h) begin
            w_base0 = GLYPH_H;
            w_base1 = GLYPH_R;
        end else if (!flag_pm) begin
            w_base0 = GLYPH_A;
            w_base1 = GLYPH_N;
        end else begin
            w_base0 = GLYPH_P;
            w_base1 = GLYPH_N;
        end

        unique case (w_mode)
            MODE_SET: begin
                if (!w_phase_next) begin
                    w_lit0 = w_base0;
                    w_lit1 = w_base1;
                end
            end
            MODE_ALARM: begin
                if (!w_phase_next) begin
                    w_lit0 = GLYPH_A;
                    w_lit1 = GLYPH_L;
                end else begin
                    w_lit0 = w_base0;
                    w_lit1 = w_base1;
                end
            end
            default: begin
                w_lit0 = w_base0;
                w_lit1 = w_base1;
            end
        endcase
    end

    // Mode, prescaler and registered segment outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= MODE_NORMAL;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_seg0  <= GLYPH_BLANK ^ POL_MASK;
            r_seg1  <= GLYPH_BLANK ^ POL_MASK;
        end else begin
            r_mode  <= w_mode;
            r_cnt   <= w_cnt_next;
            r_phase <= w_phase_next;
            r_seg0  <= w_lit0 ^ POL_MASK;
            r_seg1  <= w_lit1 ^ POL_MASK;
        end
    end

    assign seg_0       = r_seg0;
    assign seg_1       = r_seg1;
    assign blink_phase = r_phase;

endmodule

// File: tb/tb_mode_annunciator.sv
// tb_mode_annunciator: directed test-plan scenarios followed by randomized flag
// and reset activity, checked every cycle against a time-since-restart model.
module tb_mode_annunciator;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_24h = 1'b0;
    logic       flag_pm = 1'b0;
    logic       flag_set = 1'b0;
    logic       flag_alarm = 1'b0;
    logic [6:0] seg_0;
    logic [6:0] seg_1;
    logic       blink_phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles since the last restart and last effective mode
    // (0 = normal, 1 = set, 2 = alarm)
    int         m_t    = 0;
    int         m_mode = 0;
    logic       m_phase = 1'b0;
    logic [6:0] m_seg0 = 7'h7F;
    logic [6:0] m_seg1 = 7'h7F;

    mode_annunciator #(
        .CLK_HZ    (8),
        .BLINK_HZ  (1),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flag_24h   (flag_24h),
        .flag_pm    (flag_pm),
        .flag_set   (flag_set),
        .flag_alarm (flag_alarm),
        .seg_0      (seg_0),
        .seg_1      (seg_1),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: phase from elapsed cycles; glyph text chosen from the rules, then inverted
    task automatic model_edge();
        int          mode;
        logic [13:0] lit;
        logic [13:0] base;
        if (rst) begin
            m_t     = 0;
            m_mode  = 0;
            m_phase = 1'b0;
            m_seg0  = 7'b1111111;
            m_seg1  = 7'b1111111;
            return;
        end
        mode = flag_alarm ? 2 : (flag_set ? 1 : 0);
        if (mode != m_mode) m_t = 0;
        else                m_t = m_t + 1;
        m_mode  = mode;
        m_phase = ((m_t / DIV) % 2) == 1;
        if (flag_24h)     base = {7'b1110110, 7'b1010000};
        else if (flag_pm) base = {7'b1110011, 7'b1010100};
        else              base = {7'b1110111, 7'b1010100};
        case (mode)
            1:       lit = m_phase ? 14'd0 : base;
            2:       lit = m_phase ? base : {7'b1110111, 7'b0111000};
            default: lit = base;
        endcase
        m_seg0 = ~lit[13:7];
        m_seg1 = ~lit[6:0];
    endtask

    task automatic cycle(input logic r, input logic f24, input logic pm,
                         input logic st, input logic al);
        rst        = r;
        flag_24h   = f24;
        flag_pm    = pm;
        flag_set   = st;
        flag_alarm = al;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("seg_0", seg_0, m_seg0);
        check_eq("seg_1", seg_1, m_seg1);
        check_eq("blink_phase", {6'd0, blink_phase}, {6'd0, m_phase});
    endtask

    // Advance holding the flags until the DUT reports the wanted phase, bounded
    task automatic run_until_phase(input logic r, input logic f24, input logic pm,
                                   input logic st, input logic al, input logic want);
        int n = 0;
        while (blink_phase !== want && n < 4 * DIV) begin
            cycle(r, f24, pm, st, al);
            n++;
        end
        check_eq("wait_phase", {6'd0, blink_phase}, {6'd0, want});
    endtask

    initial begin
        logic r24, rpm, rst_, ral, rr;

        // 1. reset with random flags, then 24h
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        check_eq("reset_seg0", seg_0, 7'b1111111);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("hr_seg0", seg_0, 7'b0001001);
        check_eq("hr_seg1", seg_1, 7'b0101111);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 2. 12h normal, AM then PM
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("an_seg0", seg_0, 7'b0001000);
        check_eq("an_seg1", seg_1, 7'b0101011);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("pn_seg0", seg_0, 7'b0001100);

        // 3. set blink, raised mid-phase
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // 4. alarm raised during a set off-phase
        run_until_phase(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("al_seg0", seg_0, 7'b0001000);
        check_eq("al_seg1", seg_1, 7'b1000111);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // 5. alarm dropped in cycle 2 of an A/L phase
        run_until_phase(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // 6. reset during a set off-phase with set held
        run_until_phase(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("midrst_seg0", seg_0, 7'b1111111);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized flag and reset activity
        r24 = 1'b0; rpm = 1'b0; rst_ = 1'b0; ral = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) r24  = ~r24;
            if ($urandom_range(0, 9) == 0) rpm  = ~rpm;
            if ($urandom_range(0, 11) == 0) rst_ = ~rst_;
            if ($urandom_range(0, 13) == 0) ral  = ~ral;
            rr = ($urandom_range(0, 59) == 0);
            cycle(rr, r24, rpm, rst_, ral);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mode_annunciator.md
# mode_annunciator

Parametrised successor to the AM/PM/24h indicator decoder. It drives the two-digit mode annunciator ("Hr", "An", "Pn", "AL") on the 7-segment display of the clock. It blinks the indicator while the time is being set and alternates with "AL" while the alarm rings. A prescaler derives the blink rate from the system clock. All outputs are registered.

## Interface
Parameters:
- CLK_HZ, default 50_000_000: system clock frequency in Hz.
- BLINK_HZ, default 2: full blink cycles per second.
- ACTIVE_LOW, default 1: 1 means a segment is lit when its output bit is 0; 0 means lit when 1.
- Derived: DIV = CLK_HZ/(2*BLINK_HZ) cycles per half-period. Elaboration error if DIV < 2. Counter width is $clog2(DIV).

Ports:
- clk  in  1  system clock. One clock domain; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flag_24h  in  1  24-hour format selected.
- flag_pm  in  1  PM in 12-hour format. Ignored when flag_24h=1.
- flag_set  in  1  time-set mode active.
- flag_alarm  in  1  alarm ringing.
- seg_0  out  7  left character, bit order gfedcba (bit6=g).
- seg_1  out  7  right character, same bit order.
- blink_phase  out  1  0 = on half-period, 1 = off half-period. Exported for colon blinking.

## Operation
- Glyphs are defined lit-high and inverted at the output when ACTIVE_LOW=1:
  - H=1110110, r=1010000, A=1110111, n=1010100, P=1110011, L=0111000, blank=0000000.
- Base pair (seg_0/seg_1):
  - flag_24h=1: H/r.
  - else flag_pm=0: A/n.
  - else: P/n.
- Effective mode, in priority order: ALARM (flag_alarm=1) > SET (flag_set=1) > NORMAL.
- Display per mode:
  - NORMAL: base pair, regardless of phase.
  - SET: base pair on phase 0; blank/blank on phase 1.
  - ALARM: A/L on phase 0; base pair on phase 1.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps.
  - On the wrap edge (cnt==DIV-1): cnt becomes 0 and phase toggles.
- Mode register mode_q holds the effective mode of the previous cycle.
  - Any change of effective mode (any direction) forces cnt=0 and phase=0 on that edge.
  - This restart overrides the wrap.
- flag_24h/flag_pm changes never affect cnt or phase.
- Simultaneous rise of flag_set and flag_alarm: one mode change to ALARM, one restart.

## Timing
- Reset values: seg_0=seg_1=blank (7'b1111111 when ACTIVE_LOW=1), blink_phase=0, cnt=0, mode_q=NORMAL.
- Latency: outputs are computed from next-state phase/mode and the current flags, and registered.
  - A flag sampled at edge E shows on the outputs immediately after E (1-cycle latency).
  - The segment change coincides with the phase toggle.
- After a restart at edge E: phase 0 holds for exactly DIV cycles (E..E+DIV-1), then phase 1 for exactly DIV cycles. This repeats at a 50% duty cycle.
- Reset mid-operation: outputs blank on the next edge; cnt, phase and mode_q cleared.
  - If flag_set or flag_alarm is high when reset is released, the first edge is a mode change. That edge restarts the blink, giving a full DIV-cycle on-phase.
- Flags are assumed synchronous to clk; no internal synchronisers.

## Test plan
All tests use CLK_HZ=8, BLINK_HZ=1 (DIV=4), ACTIVE_LOW=1.
1. Reset then 24h:
   - Hold rst=1 for 3 cycles with flags random -> seg_0=seg_1=1111111 and blink_phase=0 on every edge.
   - Release with flag_24h=1 -> first edge seg_0=0001001, seg_1=0101111.
2. 12h format, NORMAL mode:
   - flag_24h=0, flag_pm=0 -> 0001000/0101011.
   - Set flag_pm=1 -> next edge seg_0=0001100, seg_1 unchanged.
   - Over 20 cycles: no blank output; blink_phase toggles every 4 cycles.
3. SET blink:
   - flag_pm=1; raise flag_set mid-phase -> 4 cycles 0001100/0101011, then 4 cycles 1111111/1111111, repeating.
   - blink_phase = 0 during the on-cycles and 1 during the blank cycles.
4. ALARM over SET:
   - During a SET blank phase, raise flag_alarm -> next edge 0001000/1000111 for 4 cycles, then 0001100/0101011 for 4 cycles.
5. ALARM drop back to SET:
   - Lower flag_alarm in cycle 2 of an A/L phase -> restart; base pair for 4 full cycles, then blank for 4.
6. Reset mid-blink:
   - Assert rst for 1 cycle during a SET off-phase with flag_set held high -> blank during reset.
   - After release: base pair for 4 full cycles, then blank.
